// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte types, byte addressing, FSM encoding and the
// forward/inverse S-box tables.
package aes_pkg;

  localparam int unsigned AES_BYTES = 16;

  typedef logic [7:0]             aes_byte_t;
  typedef logic [8*AES_BYTES-1:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_e;

  // Column-major layout: byte s_i occupies [byte_msb(i) -: 8], s0 at the top.
  function automatic int unsigned byte_msb(int unsigned i);
    return 127 - 8 * i;
  endfunction

  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: forward lookup when enc_dec_i=1, inverse lookup otherwise.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] sbox_i,
  input  logic       enc_dec_i,
  output logic [7:0] sbox_o
);

  assign sbox_o = enc_dec_i ? SBOX_FWD[sbox_i] : SBOX_INV[sbox_i];

endmodule

// File: rtl/aes_subbytes_serial.sv
// Serialised SubBytes/InvSubBytes: LANES shared S-boxes rewrite the held state in place,
// 16/LANES bytes-groups per transaction, then the result is held until accepted downstream.
module aes_subbytes_serial
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         enc_dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int unsigned N    = AES_BYTES / LANES;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  aes_fsm_e        fsm_q, fsm_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  aes_state_t      state_q, state_d;
  logic            mode_q, mode_d;
  logic            accept, state_en;
  int unsigned     lane_base;

  aes_byte_t sbox_in  [LANES];
  aes_byte_t sbox_out [LANES];

  assign accept    = (fsm_q == ST_IDLE) && in_valid;
  assign state_en  = accept || (fsm_q == ST_RUN);
  assign lane_base = LANES * 32'(cnt_q);

  // S-box inputs are held at zero outside RUN so the lookup logic stays quiet.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      sbox_in[l] = '0;
      if (fsm_q == ST_RUN) sbox_in[l] = state_q[byte_msb(lane_base + l) -: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : gen_lane
    aes_sbox u_sbox (
      .sbox_i    (sbox_in[g]),
      .enc_dec_i (mode_q),
      .sbox_o    (sbox_out[g])
    );
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    mode_d  = mode_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = data_in;
          mode_d  = enc_dec;
          cnt_d   = '0;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          state_d[byte_msb(lane_base + l) -: 8] = sbox_out[l];
        end
        if (cnt_q == CntW'(N - 1)) begin
          cnt_d = '0;
          fsm_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      mode_q  <= 1'b1;
    end else begin
      fsm_q <= fsm_d;
      if (state_en) begin
        cnt_q   <= cnt_d;
        state_q <= state_d;
        mode_q  <= mode_d;
      end
    end
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);
  assign data_out  = state_q;

endmodule

// File: tb/tb_aes_subbytes_serial.sv
// Directed bench for aes_subbytes_serial: a LANES=4 instance for most scenarios and a
// LANES=1 instance for the long-latency configuration.
module tb_aes_subbytes_serial;

  localparam logic [127:0] PT  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] CT  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] F63 = {16{8'h63}};
  localparam logic [127:0] F52 = {16{8'h52}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, enc_dec = 1'b1, out_ready = 1'b0;
  logic [127:0] data_in = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] data_out;

  logic         in_valid1 = 1'b0, enc_dec1 = 1'b1, out_ready1 = 1'b0;
  logic [127:0] data_in1 = '0;
  logic         in_ready1, out_valid1, busy1;
  logic [127:0] data_out1;

  int n_checks = 0;
  int n_fail   = 0;

  aes_subbytes_serial #(.LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .enc_dec   (enc_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  aes_subbytes_serial #(.LANES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .data_in   (data_in1),
    .enc_dec   (enc_dec1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .data_out  (data_out1),
    .busy      (busy1)
  );

  // Offer one state, then count edges after acceptance until out_valid (bounded).
  task automatic drive(input logic [127:0] d, input logic e, input bit toggle,
                       output logic [127:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = d;
    enc_dec  = e;
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = '0;
    lat      = 0;
    while (!out_valid && lat < 40) begin
      if (toggle) enc_dec = ~enc_dec;
      @(negedge clk);
      lat++;
    end
    res = data_out;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL rst_data_out: got %h expected 0", data_out); end
    n_checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL rst_lanes1_flags: got %b%b%b expected 100", in_ready1, out_valid1, busy1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    logic [127:0] res;
    int lat;
    drive(PT, 1'b1, 1'b0, res, lat);
    n_checks++; if (res !== CT) begin n_fail++; $display("FAIL fwd_data: got %h expected %h", res, CT); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL fwd_latency: got %0d expected 4", lat); end
    release_out();
  endtask

  task automatic test_inverse();
    logic [127:0] res;
    int lat;
    drive(CT, 1'b0, 1'b0, res, lat);
    n_checks++; if (res !== PT) begin n_fail++; $display("FAIL inv_data: got %h expected %h", res, PT); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL inv_latency: got %0d expected 4", lat); end
    release_out();
  endtask

  task automatic test_zero_state();
    logic [127:0] res;
    int lat;
    drive(128'h0, 1'b1, 1'b0, res, lat);
    n_checks++; if (res !== F63) begin n_fail++; $display("FAIL zero_fwd: got %h expected %h", res, F63); end
    release_out();
    drive(128'h0, 1'b0, 1'b0, res, lat);
    n_checks++; if (res !== F52) begin n_fail++; $display("FAIL zero_inv: got %h expected %h", res, F52); end
    release_out();
  endtask

  task automatic test_lanes1();
    int lat;
    @(negedge clk);
    in_valid1 = 1'b1;
    data_in1  = PT;
    enc_dec1  = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    data_in1  = '0;
    lat       = 0;
    while (!out_valid1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL lanes1_latency: got %0d expected 16", lat); end
    n_checks++; if (data_out1 !== CT) begin n_fail++; $display("FAIL lanes1_data: got %h expected %h", data_out1, CT); end
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL lanes1_idle: got %b expected 1", in_ready1); end
  endtask

  task automatic test_backpressure();
    logic [127:0] res;
    int lat;
    drive(PT, 1'b1, 1'b0, res, lat);
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
      n_checks++; if (data_out !== CT) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", i, data_out, CT); end
      in_valid = (i % 2 == 0);
      data_in  = ~PT;
      enc_dec  = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    data_in  = '0;
    release_out();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mode_toggle();
    logic [127:0] res;
    int lat;
    drive(PT, 1'b1, 1'b1, res, lat);
    n_checks++; if (res !== CT) begin n_fail++; $display("FAIL toggle_data: got %h expected %h", res, CT); end
    release_out();
  endtask

  task automatic test_reset_midrun();
    logic [127:0] res;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = PT;
    enc_dec  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = '0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midrun_flags: got ready=%b busy=%b expected ready=0 busy=1", in_ready, busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL midrst_data_out: got %h expected 0", data_out); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(PT, 1'b1, 1'b0, res, lat);
    n_checks++; if (res !== CT) begin n_fail++; $display("FAIL post_rst_data: got %h expected %h", res, CT); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 4", lat); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_zero_state();
    test_lanes1();
    test_backpressure();
    test_mode_toggle();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
